// File: rtl/snake_pkg.sv
// Shared grid geometry, item-placement defaults and scheduler state encodings.
package snake_pkg;
    localparam logic [7:0] GRID_W     = 8'd10;
    localparam logic [7:0] GRID_CELLS = 8'd100;
    localparam logic [7:0] EDGE_MIN   = 8'd1;
    localparam logic [7:0] EDGE_MAX   = 8'd8;

    localparam int         DEF_MAX_TRIES     = 16;
    localparam logic [7:0] DEF_FOOD_FALLBACK = 8'd55;
    localparam logic [7:0] DEF_BAR_FALLBACK  = 8'd34;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;
endpackage

// File: rtl/item_scheduler_if.sv
// Request, random-source, occupancy-lookup and placement-result bundle of the item scheduler.
interface item_scheduler_if;
    logic       food_req;
    logic       bar_req;
    logic [7:0] rnd_food;
    logic [7:0] rnd_bar;
    logic       occ_rd;
    logic [7:0] occ_addr;
    logic       occ_hit;
    logic [7:0] food_pos;
    logic [7:0] bar_pos;
    logic       food_valid;
    logic       bar_valid;
    logic       fail;
    logic       busy;

    modport master (
        output food_req, bar_req, rnd_food, rnd_bar, occ_hit,
        input  occ_rd, occ_addr, food_pos, bar_pos, food_valid, bar_valid, fail, busy
    );

    modport slave (
        input  food_req, bar_req, rnd_food, rnd_bar, occ_hit,
        output occ_rd, occ_addr, food_pos, bar_pos, food_valid, bar_valid, fail, busy
    );
endinterface

// File: rtl/cell_legal.sv
// Combinational placement legality: cell must lie in the 8x8 interior and differ from other_pos.
module cell_legal
    import snake_pkg::*;
(
    input  logic [7:0] cand,
    input  logic [7:0] other_pos,
    output logic       legal
);
    logic [7:0] row;
    logic [7:0] col;

    always_comb begin
        row   = cand / GRID_W;
        col   = cand % GRID_W;
        legal = (cand < GRID_CELLS) &&
                (row >= EDGE_MIN) && (row <= EDGE_MAX) &&
                (col >= EDGE_MIN) && (col <= EDGE_MAX) &&
                (cand != other_pos);
    end
endmodule

// File: rtl/item_scheduler.sv
// Places food/barrier items: samples random cells, rejects illegal or occupied ones, falls back after MAX_TRIES.
// Best-case commit 4 edges after the request edge; requests merge while pending, food has fixed priority.
module item_scheduler
    import snake_pkg::*;
#(
    parameter int         MAX_TRIES     = DEF_MAX_TRIES,
    parameter logic [7:0] FOOD_FALLBACK = DEF_FOOD_FALLBACK,
    parameter logic [7:0] BAR_FALLBACK  = DEF_BAR_FALLBACK
) (
    input  logic             clk,
    input  logic             rst,
    item_scheduler_if.slave  ifc
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [1:0]       state;
    logic [7:0]       cand;
    logic             sel;
    logic [TRY_W-1:0] tries;
    logic             pend_food;
    logic             pend_bar;
    logic [7:0]       food_pos;
    logic [7:0]       bar_pos;
    logic             food_valid;
    logic             bar_valid;
    logic             fail;

    logic             legal;
    logic             tries_max;
    logic             commit;
    logic             use_fb;
    logic [7:0]       commit_pos;
    logic [7:0]       other_pos;

    assign other_pos = sel ? food_pos : bar_pos;
    assign tries_max = (tries == TRY_W'(MAX_TRIES));

    cell_legal u_cell_legal (
        .cand      (cand),
        .other_pos (other_pos),
        .legal     (legal)
    );

    always_comb begin
        commit = 1'b0;
        use_fb = 1'b0;
        if (state == CHECK && !legal && tries_max) begin
            commit = 1'b1;
            use_fb = 1'b1;
        end
        if (state == WAIT) begin
            if (!ifc.occ_hit) begin
                commit = 1'b1;
            end else if (tries_max) begin
                commit = 1'b1;
                use_fb = 1'b1;
            end
        end
        commit_pos = use_fb ? (sel ? BAR_FALLBACK : FOOD_FALLBACK) : cand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= 8'd0;
            sel        <= 1'b0;
            tries      <= '0;
            pend_food  <= 1'b0;
            pend_bar   <= 1'b0;
            food_pos   <= FOOD_FALLBACK;
            bar_pos    <= BAR_FALLBACK;
            food_valid <= 1'b0;
            bar_valid  <= 1'b0;
            fail       <= 1'b0;
        end else begin
            food_valid <= 1'b0;
            bar_valid  <= 1'b0;
            fail       <= 1'b0;
            // A request on the commit edge re-arms the flag for one more placement.
            pend_food  <= ifc.food_req | (pend_food & ~(commit & ~sel));
            pend_bar   <= ifc.bar_req  | (pend_bar  & ~(commit &  sel));

            case (state)
                IDLE: begin
                    if (pend_food) begin
                        sel   <= 1'b0;
                        state <= SAMPLE;
                    end else if (pend_bar) begin
                        sel   <= 1'b1;
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    cand  <= sel ? ifc.rnd_bar : ifc.rnd_food;
                    tries <= tries + TRY_W'(1);
                    state <= CHECK;
                end
                CHECK: begin
                    if (legal)
                        state <= WAIT;
                    else if (!tries_max)
                        state <= SAMPLE;
                end
                WAIT: begin
                    if (ifc.occ_hit && !tries_max)
                        state <= SAMPLE;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                state <= IDLE;
                tries <= '0;
                fail  <= use_fb;
                if (sel) begin
                    bar_pos   <= commit_pos;
                    bar_valid <= 1'b1;
                end else begin
                    food_pos   <= commit_pos;
                    food_valid <= 1'b1;
                end
            end
        end
    end

    assign ifc.occ_rd     = (state == CHECK) && legal;
    assign ifc.occ_addr   = cand;
    assign ifc.food_pos   = food_pos;
    assign ifc.bar_pos    = bar_pos;
    assign ifc.food_valid = food_valid;
    assign ifc.bar_valid  = bar_valid;
    assign ifc.fail       = fail;
    assign ifc.busy       = (state != IDLE);
endmodule
